elevator_call_scheduler: RTL

//  Hall-call front end for the elevator car controller. Synchronises and debounces
//  per-floor call buttons, latches pending calls and picks the next target floor
//  in SCAN order from the car's current floor. Offers that floor over a valid/ack

---
 rtl/elevator_call_scheduler_if.sv | 32 +++
 rtl/elevator_call_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/elevator_call_scheduler_if.sv
// Car-side handshake bundle for the hall-call scheduler: the car's position,
// the target offer (valid/ack) and the arrival report.
interface elevator_call_scheduler_if #(
  parameter int FLOOR_W = 3
);
  logic [FLOOR_W-1:0] cur_floor;
  logic               req_valid;
  logic [FLOOR_W-1:0] req_floor;
  logic               req_ack;
  logic               arrived;
  logic [FLOOR_W-1:0] arr_floor;

  // Scheduler side: offers targets, observes the car
  modport master (
    input  cur_floor,
    output req_valid,
    output req_floor,
    input  req_ack,
    input  arrived,
    input  arr_floor
  );

  // Car side: accepts targets, reports position and arrivals
  modport slave (
    output cur_floor,
    input  req_valid,
    input  req_floor,
    output req_ack,
    output arrived,
    output arr_floor
  );
endinterface

// File: rtl/elevator_call_scheduler.sv
// Hall-call front end: synchronises and debounces call buttons, latches pending
// calls, picks the next target in SCAN order and offers it to the car controller.
module elevator_call_scheduler #(
  parameter int NUM_FLOORS      = 7,
  parameter int FLOOR_W         = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DB_W            = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] btn,
  elevator_call_scheduler_if.master car,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_OFFER,
    S_SERVE
  } state_t;

  localparam logic [DB_W-1:0]    DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLR  = FLOOR_W'(NUM_FLOORS);

  state_t                r_state;
  state_t                w_stateNext;
  logic [NUM_FLOORS-1:0] r_sync1;
  logic [NUM_FLOORS-1:0] r_sync2;
  logic [NUM_FLOORS-1:0] r_db;
  logic [NUM_FLOORS-1:0] r_dbPrev;
  logic [NUM_FLOORS-1:0] r_pending;
  logic [DB_W-1:0]       r_cnt [NUM_FLOORS];
  logic [FLOOR_W-1:0]    r_reqFloor;
  logic                  r_dirUp;

  logic [NUM_FLOORS-1:0] w_rise;
  logic [NUM_FLOORS-1:0] w_clr;
  logic [NUM_FLOORS-1:0] w_avail;
  logic [NUM_FLOORS-1:0] w_pendNext;
  logic [FLOOR_W-1:0]    w_cur;
  logic [FLOOR_W-1:0]    w_target;
  logic [FLOOR_W-1:0]    w_lowAbove;
  logic [FLOOR_W-1:0]    w_highBelow;
  logic                  w_foundAbove;
  logic                  w_foundBelow;
  logic                  w_atCur;
  logic                  w_arrValid;
  logic                  w_dirNext;
  logic                  w_loadTarget;

  // Two-flop synchroniser on the asynchronous button inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: the accepted level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db     <= '0;
      r_dbPrev <= '0;
      for (int i = 0; i < NUM_FLOORS; i++) r_cnt[i] <= '0;
    end else begin
      r_dbPrev <= r_db;
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_LAST) begin
          r_cnt[i] <= '0;
          r_db[i]  <= r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Call set/clear masks; an arrival clears its floor and beats a simultaneous new press
  always_comb begin
    w_rise     = r_db & ~r_dbPrev;
    w_arrValid = car.arrived && (car.arr_floor != '0) && (car.arr_floor <= TOP_FLR);
    w_clr      = w_arrValid ? (NUM_FLOORS'(1) << (car.arr_floor - 1'b1)) : '0;
    w_pendNext = (r_pending | w_rise) & ~w_clr;
    w_avail    = r_pending & ~w_clr;
    if (car.cur_floor == '0)         w_cur = FLOOR_W'(1);
    else if (car.cur_floor > TOP_FLR) w_cur = TOP_FLR;
    else                             w_cur = car.cur_floor;
    w_atCur    = w_avail[w_cur - 1'b1];
  end

  // Nearest outstanding call above and below the car
  always_comb begin
    w_lowAbove   = '0;
    w_foundAbove = 1'b0;
    w_highBelow  = '0;
    w_foundBelow = 1'b0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (w_avail[i] && (FLOOR_W'(i + 1) > w_cur)) begin
        w_lowAbove   = FLOOR_W'(i + 1);
        w_foundAbove = 1'b1;
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (w_avail[i] && (FLOOR_W'(i + 1) < w_cur)) begin
        w_highBelow  = FLOOR_W'(i + 1);
        w_foundBelow = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_stateNext;
  end

  // Next-state and SCAN target selection
  always_comb begin
    w_stateNext  = r_state;
    w_target     = r_reqFloor;
    w_dirNext    = r_dirUp;
    w_loadTarget = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pending != '0) w_stateNext = S_SELECT;
      end
      S_SELECT: begin
        if (w_avail == '0) begin
          w_stateNext = S_IDLE;
        end else begin
          w_stateNext  = S_OFFER;
          w_loadTarget = 1'b1;
          if (w_atCur) begin
            w_target = w_cur;
          end else if (r_dirUp) begin
            if (w_foundAbove) begin
              w_target = w_lowAbove;
            end else begin
              w_target  = w_highBelow;
              w_dirNext = 1'b0;
            end
          end else begin
            if (w_foundBelow) begin
              w_target = w_highBelow;
            end else begin
              w_target  = w_lowAbove;
              w_dirNext = 1'b1;
            end
          end
        end
      end
      S_OFFER: begin
        if (car.req_ack) w_stateNext = S_SERVE;
      end
      S_SERVE: begin
        if (w_arrValid && (car.arr_floor == r_reqFloor))
          w_stateNext = (w_pendNext != '0) ? S_SELECT : S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Pending calls, offered target and sweep direction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_reqFloor <= FLOOR_W'(1);
      r_dirUp    <= 1'b1;
    end else begin
      r_pending <= w_pendNext;
      if (w_loadTarget) begin
        r_reqFloor <= w_target;
        r_dirUp    <= w_dirNext;
      end
    end
  end

  assign car.req_valid = (r_state == S_OFFER);
  assign car.req_floor = r_reqFloor;
  assign pending       = r_pending;
  assign dir_up        = r_dirUp;

endmodule
